// File: rtl/trace_capture_ctrl.sv
// Trace capture window sequencer: arm / start-PC / stop-PC control with a capture FIFO
// streamed out over valid/ready. Optional per-entry timestamps via TRACE_CAPTURE_TIMESTAMP_EN.
module trace_capture_ctrl #(
    parameter int FIFO_DEPTH    = 16,
    parameter int PC_WIDTH      = 64,
    parameter int INSTR_WIDTH   = 32,
    parameter int OVF_CNT_WIDTH = 16,
    parameter int TS_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_arm,
    input  logic                     cfg_abort,
    input  logic                     cfg_use_start,
    input  logic [PC_WIDTH-1:0]      cfg_start_addr,
    input  logic [PC_WIDTH-1:0]      cfg_stop_addr,
    input  logic                     pc_valid,
    input  logic [PC_WIDTH-1:0]      pc,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     drop_instr,
    output logic                     m_valid,
    input  logic                     m_ready,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    output logic [TS_WIDTH+PC_WIDTH+INSTR_WIDTH-1:0] m_data,
`else
    output logic [PC_WIDTH+INSTR_WIDTH-1:0]          m_data,
`endif
    output logic                     m_last,
    output logic [2:0]               state_o,
    output logic                     busy,
    output logic [OVF_CNT_WIDTH-1:0] overflow_count
);

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int DATA_W = TS_WIDTH + PC_WIDTH + INSTR_WIDTH;
`else
    localparam int DATA_W = PC_WIDTH + INSTR_WIDTH;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_param_check
        $error("trace_capture_ctrl: FIFO_DEPTH must be a power of 2 >= 4 and TS_WIDTH >= 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_q, ovf_d;
    logic                   busy_q, busy_d;

    logic [DATA_W-1:0]      data_mem [FIFO_DEPTH];
    logic                   last_mem [FIFO_DEPTH];

    logic                   push_s;
    logic                   push_last_s;
    logic                   pop_s;
    logic                   flush_s;
    logic                   start_hit_s;
    logic                   stop_hit_s;
    logic [DATA_W-1:0]      wr_data_s;

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    ts_q;

    // Free-running timestamp; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= {TS_WIDTH{1'b0}};
        end else begin
            ts_q <= ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign wr_data_s = {ts_q, pc, instr};
`else
    assign wr_data_s = {pc, instr};
`endif

    assign start_hit_s = pc_valid && (pc == cfg_start_addr);
    assign stop_hit_s  = pc_valid && (pc == cfg_stop_addr);
    assign pop_s       = (count_q != {CNT_W{1'b0}}) && m_ready;

    // Next-state, push decision and overflow accounting
    always_comb begin
        state_d     = state_q;
        push_s      = 1'b0;
        push_last_s = 1'b0;
        flush_s     = 1'b0;
        ovf_d       = ovf_q;
        if (cfg_abort) begin
            state_d = IDLE;
            flush_s = 1'b1;
        end else if (cfg_arm && (state_q == IDLE || state_q == DONE)) begin
            ovf_d   = {OVF_CNT_WIDTH{1'b0}};
            state_d = cfg_use_start ? ARMED : CAPTURE;
        end else begin
            case (state_q)
                ARMED: begin
                    // The FIFO is always empty here, so the start entry always fits
                    if (start_hit_s) begin
                        push_s  = 1'b1;
                        state_d = CAPTURE;
                    end else begin
                        state_d = ARMED;
                    end
                end
                CAPTURE: begin
                    // Kept entries stop one short of full so the stop entry always fits
                    if (stop_hit_s) begin
                        push_s      = 1'b1;
                        push_last_s = 1'b1;
                        state_d     = DRAIN;
                    end else if (pc_valid && !drop_instr) begin
                        if (count_q < CNT_W'(FIFO_DEPTH - 1)) begin
                            push_s = 1'b1;
                        end else if (ovf_q != {OVF_CNT_WIDTH{1'b1}}) begin
                            ovf_d = ovf_q + {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            ovf_d = ovf_q;
                        end
                    end else begin
                        state_d = CAPTURE;
                    end
                end
                DRAIN: begin
                    if (pop_s && last_mem[rd_ptr_q]) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_s};
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_s};
            count_d  = count_q + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
        end
        busy_d = (state_d == ARMED) || (state_d == CAPTURE) || (state_d == DRAIN);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= {OVF_CNT_WIDTH{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem[wr_ptr_q] <= wr_data_s;
            last_mem[wr_ptr_q] <= push_last_s;
        end
    end

    assign m_valid        = (count_q != {CNT_W{1'b0}});
    assign m_data         = m_valid ? data_mem[rd_ptr_q] : {DATA_W{1'b0}};
    assign m_last         = m_valid & last_mem[rd_ptr_q];
    assign state_o        = state_q;
    assign busy           = busy_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl: randomized stimulus against a queue-based
// behavioural model of the capture window. Set TRACE_CAPTURE_TIMESTAMP_EN to cover timestamps.
module tb_trace_capture_ctrl;

    localparam int DEPTH = 4;
    localparam int PCW   = 64;
    localparam int IW    = 32;
    localparam int OVW   = 16;
    localparam int TSW   = 32;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int DW = TSW + PCW + IW;
`else
    localparam int DW = PCW + IW;
`endif

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n, cfg_arm, cfg_abort, cfg_use_start;
    logic [PCW-1:0]  cfg_start_addr, cfg_stop_addr, pc;
    logic [IW-1:0]   instr;
    logic            pc_valid, drop_instr, m_valid, m_ready, m_last, busy;
    logic [DW-1:0]   m_data;
    logic [2:0]      state_o;
    logic [OVW-1:0]  overflow_count;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: state as spec code, FIFO as a queue
    int              ms;
    int unsigned     movf;
    logic [TSW-1:0]  mts;
    ent_t            mq[$];
    ent_t            pushed[$];
    ent_t            got[$];

    trace_capture_ctrl #(
        .FIFO_DEPTH(DEPTH), .PC_WIDTH(PCW), .INSTR_WIDTH(IW),
        .OVF_CNT_WIDTH(OVW), .TS_WIDTH(TSW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_use_start(cfg_use_start), .cfg_start_addr(cfg_start_addr),
        .cfg_stop_addr(cfg_stop_addr), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .drop_instr(drop_instr), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .state_o(state_o), .busy(busy), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    function automatic logic [PCW-1:0] pc_of(ent_t e);
        return e.data[IW +: PCW];
    endfunction

    task automatic model_push(bit last);
        ent_t e;
        e.last = last;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
        e.data = {mts, pc, instr};
`else
        e.data = {pc, instr};
`endif
        mq.push_back(e);
        pushed.push_back(e);
    endtask

    // One clock: record the DUT handshake, advance the model, step past the edge
    task automatic cycle();
        ent_t e;
        bit   do_pop;
        int   occ;
        if (m_valid && m_ready) begin
            e.last = m_last;
            e.data = m_data;
            got.push_back(e);
        end
        if (!rst_n) begin
            ms = 0; movf = 0; mts = '0; mq.delete();
        end else begin
            do_pop = (mq.size() != 0) && m_ready;
            occ    = mq.size();
            if (cfg_abort) begin
                ms = 0; mq.delete(); do_pop = 1'b0;
            end else if (cfg_arm && (ms == 0 || ms == 4)) begin
                movf = 0; ms = cfg_use_start ? 1 : 2;
            end else if (ms == 1) begin
                if (pc_valid && pc == cfg_start_addr) begin model_push(1'b0); ms = 2; end
            end else if (ms == 2) begin
                if (pc_valid && pc == cfg_stop_addr) begin
                    model_push(1'b1); ms = 3;
                end else if (pc_valid && !drop_instr) begin
                    if (occ < DEPTH - 1) model_push(1'b0);
                    else if (movf < (1 << OVW) - 1) movf++;
                end
            end else if (ms == 3) begin
                if (do_pop && mq[0].last) ms = 4;
            end
            if (do_pop) void'(mq.pop_front());
            mts = mts + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_arm = 0; cfg_abort = 0; pc_valid = 0; drop_instr = 0; pc = '0; instr = '0;
    endtask

    task automatic arm(bit use_start, logic [PCW-1:0] s, logic [PCW-1:0] t);
        cfg_use_start = use_start; cfg_start_addr = s; cfg_stop_addr = t;
        cfg_arm = 1; cycle(); cfg_arm = 0;
    endtask

    task automatic drive_pc(logic [PCW-1:0] p, bit drop);
        pc_valid = 1; pc = p; instr = $urandom; drop_instr = drop;
        cycle();
        pc_valid = 0; drop_instr = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); m_ready = 0; rst_n = 0;
        cycle(); cycle();
        nchecks += 6;
        if (m_valid !== 1'b0) begin nerrors++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
        if (m_last !== 1'b0) begin nerrors++; $display("FAIL reset_last: got %0b want 0", m_last); end
        if (m_data !== '0) begin nerrors++; $display("FAIL reset_data: got %0h want 0", m_data); end
        if (state_o !== 3'd0) begin nerrors++; $display("FAIL reset_state: got %0d want 0", state_o); end
        if (busy !== 1'b0) begin nerrors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (overflow_count !== '0) begin nerrors++; $display("FAIL reset_ovf: got %0d want 0", overflow_count); end
        rst_n = 1;
        cycle();
    endtask

    task automatic test_window();
        logic [PCW-1:0] exp_pc [3];
        exp_pc[0] = 64'h1000; exp_pc[1] = 64'h1010; exp_pc[2] = 64'h1040;
        pushed.delete(); got.delete(); m_ready = 1;
        arm(1'b1, 64'h1000, 64'h1040);
        for (int k = 0; k < 17; k++) drive_pc(64'h1000 + 64'(4 * k), (k == 4) ? 1'b0 : 1'b1);
        for (int n = 0; n < 20 && state_o !== 3'd4; n++) cycle();
        nchecks += 3;
        if (state_o !== 3'd4 || ms != 4) begin nerrors++; $display("FAIL window_done: got %0d want 4", state_o); end
        if (overflow_count !== 16'd0) begin nerrors++; $display("FAIL window_ovf: got %0d want 0", overflow_count); end
        if (got.size() != 3 || pushed.size() != 3) begin
            nerrors++; $display("FAIL window_count: got %0d want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nchecks += 2;
                if (got[i] !== pushed[i]) begin nerrors++; $display("FAIL window_entry%0d: got %0h want %0h", i, got[i], pushed[i]); end
                if (pc_of(got[i]) !== exp_pc[i] || got[i].last !== (i == 2)) begin
                    nerrors++; $display("FAIL window_pc%0d: got %0h/%0b want %0h/%0b", i, pc_of(got[i]), got[i].last, exp_pc[i], i == 2);
                end
            end
        end
    endtask

    task automatic test_overflow();
        pushed.delete(); got.delete(); m_ready = 0;
        arm(1'b0, 64'h0, 64'h5000);
        for (int k = 0; k < 5; k++) drive_pc(64'h4000 + 64'(4 * k), 1'b0);
        drive_pc(64'h5000, 1'b1);
        nchecks += 3;
        if (overflow_count !== 16'd2 || movf != 2) begin nerrors++; $display("FAIL ovf_count: got %0d want 2", overflow_count); end
        if (state_o !== 3'd3) begin nerrors++; $display("FAIL ovf_drain: got %0d want 3", state_o); end
        if (mq.size() != 4 || m_valid !== 1'b1) begin nerrors++; $display("FAIL ovf_occupancy: got %0d want 4", mq.size()); end
        m_ready = 1;
        for (int n = 0; n < 10 && state_o !== 3'd4; n++) cycle();
        nchecks += 2;
        if (state_o !== 3'd4) begin nerrors++; $display("FAIL ovf_done: got %0d want 4", state_o); end
        if (got.size() != 4) begin
            nerrors++; $display("FAIL ovf_beats: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nchecks++;
                if (got[i] !== pushed[i]) begin nerrors++; $display("FAIL ovf_entry%0d: got %0h want %0h", i, got[i], pushed[i]); end
            end
            nchecks += 2;
            if (got[3].last !== 1'b1 || pc_of(got[3]) !== 64'h5000) begin nerrors++; $display("FAIL ovf_last: got %0h want 5000", pc_of(got[3])); end
            if (pc_of(got[2]) !== 64'h4008) begin nerrors++; $display("FAIL ovf_third: got %0h want 4008", pc_of(got[2])); end
        end
    endtask

    task automatic test_backpressure();
        logic [PCW-1:0] base;
        logic           pv, pr, pl;
        logic [DW-1:0]  pd;
        for (int it = 0; it < 4; it++) begin
            pushed.delete(); got.delete();
            base = {32'h0, $urandom} & ~64'hff;
            m_ready = $urandom_range(0, 1);
            arm(1'b1, base, base + 64'd28);
            for (int c = 0; c < 200 && ms != 4; c++) begin
                m_ready = ~m_ready;
                pc_valid = ($urandom_range(0, 3) != 0);
                pc = base + 64'(4 * $urandom_range(0, 7));
                instr = $urandom; drop_instr = $urandom_range(0, 1);
                cfg_arm = (ms >= 1 && ms <= 3 && $urandom_range(0, 15) == 0);
                if (c >= 60) begin
                    pc_valid = 1;
                    pc = (ms == 1) ? base : base + 64'd28;
                end
                pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
                cycle();
                cfg_arm = 0;
                nchecks += 3;
                if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) begin
                    nerrors++; $display("FAIL bp_stable: got %0b/%0h want 1/%0h", m_valid, m_data, pd);
                end
                if (state_o !== 3'(ms) || busy !== (ms >= 1 && ms <= 3)) begin
                    nerrors++; $display("FAIL bp_state: got %0d/%0b want %0d", state_o, busy, ms);
                end
                if (overflow_count !== OVW'(movf)) begin nerrors++; $display("FAIL bp_ovf: got %0d want %0d", overflow_count, movf); end
            end
            pc_valid = 0; drop_instr = 0;
            nchecks += 2;
            if (state_o !== 3'd4) begin nerrors++; $display("FAIL bp_done: got %0d want 4", state_o); end
            if (got.size() != pushed.size()) begin
                nerrors++; $display("FAIL bp_beats: got %0d want %0d", got.size(), pushed.size());
            end else begin
                for (int i = 0; i < got.size(); i++) begin
                    nchecks++;
                    if (got[i] !== pushed[i]) begin nerrors++; $display("FAIL bp_entry%0d: got %0h want %0h", i, got[i], pushed[i]); end
                end
            end
        end
    endtask

    task automatic test_abort();
        pushed.delete(); got.delete(); m_ready = 0;
        arm(1'b0, 64'h0, 64'h3000);
        for (int k = 0; k < 5; k++) drive_pc(64'h3100 + 64'(4 * k), 1'b0);
        nchecks++;
        if (m_valid !== 1'b1 || state_o !== 3'd2 || mq.size() != 3) begin nerrors++; $display("FAIL abort_pre: got %0b/%0d want 1/2", m_valid, state_o); end
        cfg_abort = 1; cycle(); cfg_abort = 0;
        nchecks += 3;
        if (m_valid !== 1'b0) begin nerrors++; $display("FAIL abort_valid: got %0b want 0", m_valid); end
        if (state_o !== 3'd0 || busy !== 1'b0) begin nerrors++; $display("FAIL abort_state: got %0d want 0", state_o); end
        if (overflow_count !== 16'd2) begin nerrors++; $display("FAIL abort_ovf_kept: got %0d want 2", overflow_count); end
        pushed.delete(); got.delete();
        arm(1'b0, 64'h0, 64'h3000);
        nchecks++;
        if (overflow_count !== 16'd0) begin nerrors++; $display("FAIL rearm_ovf: got %0d want 0", overflow_count); end
        m_ready = 1;
        drive_pc(64'h3200, 1'b0);
        drive_pc(64'h3000, 1'b0);
        for (int n = 0; n < 10 && state_o !== 3'd4; n++) cycle();
        nchecks += 2;
        if (state_o !== 3'd4) begin nerrors++; $display("FAIL rearm_done: got %0d want 4", state_o); end
        if (got.size() != 2 || pc_of(got[0]) !== 64'h3200 || got[1] !== pushed[1] || got[1].last !== 1'b1) begin
            nerrors++; $display("FAIL rearm_entries: got %0d beats want 2 new", got.size());
        end
    endtask

    task automatic test_start_eq_stop();
        pushed.delete(); got.delete(); m_ready = 1;
        arm(1'b0, 64'h2000, 64'h2000);
        nchecks++;
        if (state_o !== 3'd2) begin nerrors++; $display("FAIL same_capture: got %0d want 2", state_o); end
        drive_pc(64'h1ff8, 1'b0);
        drive_pc(64'h2000, 1'b1);
        for (int n = 0; n < 10 && state_o !== 3'd4; n++) cycle();
        drive_pc(64'h2000, 1'b0);
        cycle();
        nchecks += 2;
        if (state_o !== 3'd4 || m_valid !== 1'b0) begin nerrors++; $display("FAIL same_done: got %0d/%0b want 4/0", state_o, m_valid); end
        if (got.size() != 2 || got[1].last !== 1'b1 || pc_of(got[1]) !== 64'h2000 || got[0].last !== 1'b0) begin
            nerrors++; $display("FAIL same_entries: got %0d beats want 2", got.size());
        end
        pushed.delete(); got.delete();
        arm(1'b1, 64'h2000, 64'h2000);
        drive_pc(64'h2000, 1'b1);
        drive_pc(64'h2004, 1'b0);
        drive_pc(64'h2000, 1'b1);
        for (int n = 0; n < 10 && state_o !== 3'd4; n++) cycle();
        nchecks++;
        if (got.size() != 3 || got[0].last !== 1'b0 || got[2].last !== 1'b1 || got[2] !== pushed[2]) begin
            nerrors++; $display("FAIL armed_same_entries: got %0d beats want 3", got.size());
        end
    endtask

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [TSW-1:0] d;
        pushed.delete(); got.delete(); m_ready = 0;
        arm(1'b0, 64'h0, 64'h6000);
        drive_pc(64'h6100, 1'b0);
        for (int n = 0; n < 4; n++) cycle();
        drive_pc(64'h6104, 1'b0);
        m_ready = 1;
        for (int n = 0; n < 10 && got.size() < 2; n++) cycle();
        nchecks++;
        if (got.size() != 2) begin
            nerrors++; $display("FAIL ts_beats: got %0d want 2", got.size());
        end else begin
            d = got[1].data[DW-1 -: TSW] - got[0].data[DW-1 -: TSW];
            nchecks += 2;
            if (d !== 32'd5) begin nerrors++; $display("FAIL ts_delta: got %0d want 5", d); end
            if (got[0] !== pushed[0]) begin nerrors++; $display("FAIL ts_entry: got %0h want %0h", got[0], pushed[0]); end
        end
        cfg_abort = 1; cycle(); cfg_abort = 0;
    endtask
`endif

    task automatic test_reset_midcapture();
        m_ready = 0;
        arm(1'b0, 64'h0, 64'h7000);
        drive_pc(64'h7100, 1'b0);
        drive_pc(64'h7104, 1'b0);
        rst_n = 0; cycle(); rst_n = 1;
        nchecks += 2;
        if (m_valid !== 1'b0 || m_data !== '0) begin nerrors++; $display("FAIL midreset_fifo: got %0b/%0h want 0/0", m_valid, m_data); end
        if (state_o !== 3'd0 || busy !== 1'b0) begin nerrors++; $display("FAIL midreset_state: got %0d want 0", state_o); end
    endtask

    initial begin
        rst_n = 0; m_ready = 0; cfg_use_start = 0;
        cfg_start_addr = '0; cfg_stop_addr = '0;
        idle_inputs();
        ms = 0; movf = 0; mts = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_window();
        test_overflow();
        test_backpressure();
        test_abort();
        test_start_eq_stop();
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        test_reset_midcapture();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
